data_mem_responder: RTL and testbench



---
 rtl/data_mem_responder.sv | 129 ++++++++++++
 tb/tb_data_mem_responder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder: serves EX/MEM loads/stores from a word array after WAIT_CYCLES wait states.
// Optional macro DMEM_ACCESS_CNT_EN adds rd_cnt/wr_cnt completed-access counters.
module data_mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        ready,
  output logic        busy,
  output logic        err
`ifdef DMEM_ACCESS_CNT_EN
  ,
  output logic [15:0] rd_cnt,
  output logic [15:0] wr_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } state_t;

  localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic                r_rd;
  logic                r_wr;
  logic                r_mis;
  logic [ADDR_W-1:0]   r_idx;
  logic [31:0]         r_wd;
  logic [31:0]         r_mem [2**ADDR_W];

  logic                w_req;
  logic                w_accept;
  logic                w_finish;
  logic                w_a_rd;
  logic                w_a_wr;
  logic                w_a_mis;
  logic                w_a_err;
  logic [ADDR_W-1:0]   w_a_idx;
  logic [31:0]         w_a_wd;
  logic                w_store;
  logic                w_load;
  logic                w_unused_addr;

  assign w_req    = MemRead | MemWrite;
  assign w_accept = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && w_req;

  // With no wait states the access happens on the acceptance edge, so it uses the live request.
  assign w_finish = ZERO_WAIT ? w_accept : ((r_state == ST_WAIT) && (r_cnt == 4'd1));
  assign w_a_rd   = ZERO_WAIT ? MemRead                  : r_rd;
  assign w_a_wr   = ZERO_WAIT ? MemWrite                 : r_wr;
  assign w_a_mis  = ZERO_WAIT ? (addr[1:0] != 2'b00)     : r_mis;
  assign w_a_idx  = ZERO_WAIT ? addr[ADDR_W+1:2]         : r_idx;
  assign w_a_wd   = ZERO_WAIT ? wd                       : r_wd;
  assign w_a_err  = w_a_mis | (w_a_rd & w_a_wr);

  // A conflicting request behaves as a store; misalignment suppresses the access entirely.
  assign w_store  = w_finish & w_a_wr & ~w_a_mis & ~rst;
  assign w_load   = w_finish & w_a_rd & ~w_a_wr & ~w_a_mis;

  assign busy     = ~rst & (w_accept | (r_state == ST_WAIT));

  assign w_unused_addr = ^addr[31:ADDR_W+2];

  // NOTE: the array has no reset branch so it maps onto plain RAM; its contents survive rst.
  always_ff @(posedge clk) begin
    if (w_store) r_mem[w_a_idx] <= w_a_wd;
  end

  // NOTE: every register here uses <= so all updates see pre-edge values, avoiding order races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_mis   <= 1'b0;
      r_idx   <= '0;
      r_wd    <= 32'd0;
      rd      <= 32'd0;
      ready   <= 1'b0;
      err     <= 1'b0;
`ifdef DMEM_ACCESS_CNT_EN
      rd_cnt  <= 16'd0;
      wr_cnt  <= 16'd0;
`endif
    end else begin
      ready <= w_finish;
      err   <= w_finish & w_a_err;
      if (w_load) rd <= r_mem[w_a_idx];
`ifdef DMEM_ACCESS_CNT_EN
      if (w_finish && !w_a_err) begin
        if (w_a_wr) wr_cnt <= wr_cnt + 16'd1;
        else        rd_cnt <= rd_cnt + 16'd1;
      end
`endif
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_req) begin
            r_rd    <= MemRead;
            r_wr    <= MemWrite;
            r_mis   <= (addr[1:0] != 2'b00);
            r_idx   <= addr[ADDR_W+1:2];
            r_wd    <= wd;
            r_cnt   <= 4'(WAIT_CYCLES);
            r_state <= ZERO_WAIT ? ST_DONE : ST_WAIT;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) r_state <= ST_DONE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: WAIT_CYCLES=2 instance under random traffic
// against a word-array reference model, plus a WAIT_CYCLES=0 instance for back-to-back timing.
module tb_data_mem_responder;

  localparam int ADDR_W = 8;
  localparam int W      = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [31:0] addr, wd, rd;
  logic        ready, busy, err;
  logic        mem_read0, mem_write0;
  logic [31:0] addr0, wd0, rd0;
  logic        ready0, busy0, err0;
`ifdef DMEM_ACCESS_CNT_EN
  logic [15:0] rd_cnt, wr_cnt, rd_cnt0, wr_cnt0;
`endif

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .MemRead(mem_read), .MemWrite(mem_write),
    .addr(addr), .wd(wd), .rd(rd), .ready(ready), .busy(busy), .err(err)
`ifdef DMEM_ACCESS_CNT_EN
    , .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
`endif
  );

  data_mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .MemRead(mem_read0), .MemWrite(mem_write0),
    .addr(addr0), .wd(wd0), .rd(rd0), .ready(ready0), .busy(busy0), .err(err0)
`ifdef DMEM_ACCESS_CNT_EN
    , .rd_cnt(rd_cnt0), .wr_cnt(wr_cnt0)
`endif
  );

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m_mem [2**ADDR_W];
  logic [31:0] m_rd;
  int          m_rdc, m_wrc;
  int          n_cmp = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: word-addressed array, rd holds unless an aligned pure load completes.
  task automatic model(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    bit mis;
    bit e;
    int idx;
    mis = (a % 4) != 0;
    e   = mis || (r && w);
    idx = int'((a / 4) % (2**ADDR_W));
    if (w && !mis)      m_mem[idx] = d;
    else if (r && !mis) m_rd = m_mem[idx];
    if (!e) begin
      if (w) m_wrc++;
      else   m_rdc++;
    end
    q.push_back('{rd: m_rd, err: e});
  endtask

  // Called at posedge+1; returns at posedge+1 of the DONE cycle.
  task automatic do_txn(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                        input bit scramble);
    mem_read  = r;
    mem_write = w;
    addr      = a;
    wd        = d;
    model(r, w, a, d);
    for (int i = 0; i <= W; i++) begin
      @(negedge clk);
      chk("busy_hold", {31'd0, busy}, 32'd1);
      if (i > 0) chk("ready_early", {31'd0, ready}, 32'd0);
      @(posedge clk);
      #1;
      if (scramble && i < W) begin
        addr = $urandom;
        wd   = $urandom;
      end
    end
    chk("ready_latency", {31'd0, ready}, 32'd1);
  endtask

  task automatic idle(input int n);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("busy_idle", {31'd0, busy}, 32'd0);
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && ready === 1'b1) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL spurious_ready: got ready=1 expected no pending transaction at %0t", $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rd", rd, e.rd);
        chk("err", {31'd0, err}, {31'd0, e.err});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    int          op;
    rst = 1'b1;
    {mem_read, mem_write, addr, wd}     = '0;
    {mem_read0, mem_write0, addr0, wd0} = '0;
    m_rd = 32'd0; m_rdc = 0; m_wrc = 0;
    #12;
    chk("rst_rd", rd, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed: store/load, misaligned store, wrap, conflict.
    do_txn(0, 1, 32'h10, 32'hDEADBEEF, 0);
    idle(1);
    do_txn(1, 0, 32'h10, 32'h0, 0);
    idle(1);
    do_txn(0, 1, 32'h13, 32'h55, 0);
    do_txn(1, 0, 32'h10, 32'h0, 0);
    idle(1);
    do_txn(0, 1, 32'h400, 32'hA5, 0);
    do_txn(1, 0, 32'h0, 32'h0, 0);
    idle(1);
    do_txn(1, 1, 32'h30, 32'h1234, 0);
    do_txn(1, 0, 32'h30, 32'h0, 0);
    idle(1);

    // Fill the whole array so every later load has a known value.
    for (int i = 0; i < 2**ADDR_W; i++) do_txn(0, 1, 32'(i * 4), $urandom, 0);
    idle(2);

    for (int n = 0; n < 300; n++) begin
      op = $urandom_range(0, 9);
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      do_txn(op < 5, op >= 4, a, $urandom, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(2);
`ifdef DMEM_ACCESS_CNT_EN
    chk("rd_cnt", {16'd0, rd_cnt}, 32'(m_rdc % 65536));
    chk("wr_cnt", {16'd0, wr_cnt}, 32'(m_wrc % 65536));
`endif

    // Reset during WAIT of a store: dropped, no ready, busy low at once.
    mem_write = 1'b1;
    addr      = 32'h20;
    wd        = ~m_mem[8];
    @(posedge clk);
    #1;
    chk("busy_wait", {31'd0, busy}, 32'd1);
    rst       = 1'b1;
    mem_write = 1'b0;
    #1;
    chk("busy_rst", {31'd0, busy}, 32'd0);
    chk("ready_rst", {31'd0, ready}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("ready_in_rst", {31'd0, ready}, 32'd0);
    chk("rd_after_rst", rd, 32'd0);
    rst = 1'b0;
    m_rd = 32'd0; m_rdc = 0; m_wrc = 0;
    @(posedge clk);
    #1;
    do_txn(1, 0, 32'h20, 32'h0, 0);
    idle(2);
`ifdef DMEM_ACCESS_CNT_EN
    chk("rd_cnt_post_rst", {16'd0, rd_cnt}, 32'(m_rdc));
    chk("wr_cnt_post_rst", {16'd0, wr_cnt}, 32'(m_wrc));
`endif

    // Zero-wait instance: consecutive ready pulses with no idle bubble.
    mem_write0 = 1'b1; addr0 = 32'h0; wd0 = 32'h11;
    @(posedge clk); #1;
    chk("z_ready_st0", {31'd0, ready0}, 32'd1);
    addr0 = 32'h4; wd0 = 32'h22;
    @(posedge clk); #1;
    chk("z_ready_st1", {31'd0, ready0}, 32'd1);
    chk("z_err_st1", {31'd0, err0}, 32'd0);
    mem_write0 = 1'b0; mem_read0 = 1'b1; addr0 = 32'h0;
    @(posedge clk); #1;
    chk("z_ready_ld0", {31'd0, ready0}, 32'd1);
    chk("z_rd_ld0", rd0, 32'h11);
    addr0 = 32'h4;
    @(negedge clk);
    chk("z_busy_b2b", {31'd0, busy0}, 32'd1);
    @(posedge clk); #1;
    chk("z_ready_ld1", {31'd0, ready0}, 32'd1);
    chk("z_rd_ld1", rd0, 32'h22);
    mem_read0 = 1'b0;
    @(negedge clk);
    chk("z_busy_idle", {31'd0, busy0}, 32'd0);
    @(posedge clk); #1;
    chk("z_ready_idle", {31'd0, ready0}, 32'd0);
    chk("z_rd_hold", rd0, 32'h22);

    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
